// File: rtl/sid_env_amp.sv
// sid_env_amp: voice amplitude stage. Multiplies the offset-binary waveform
// DAC code by the unsigned envelope value. The result is a signed
// WAV_BITS+ENV_BITS sample. A sequential multiplier is started by the phi2
// phase strobe.
// Optional feature macro: SID_ENV_AMP_BOOTH_EN
//   Defined:   radix-4 Booth, one digit per edge, 5-edge latency.
//   Undefined: radix-2 shift-add, one env bit per edge, 8-edge latency.

package sid;
    typedef logic [1:0] phase_t;
    localparam int PHI1 = 0;
    localparam int PHI2 = 1;
endpackage

module sid_env_amp #(
    parameter int WAV_BITS = 12,
    parameter int ENV_BITS = 8
) (
    input  logic                         clk,
    input  logic                         res_n,
    input  sid::phase_t                  phase,
    input  logic [WAV_BITS-1:0]          wav,
    input  logic [ENV_BITS-1:0]          env,
    output logic [WAV_BITS+ENV_BITS-1:0] out,
    output logic                         out_valid,
    output logic                         overrun
);
    localparam int OUT_BITS = WAV_BITS + ENV_BITS;
`ifdef SID_ENV_AMP_BOOTH_EN
    localparam int NSTEPS = ENV_BITS / 2 + 1;
`else
    localparam int NSTEPS = ENV_BITS;
`endif
    localparam int CNT_W = $clog2(NSTEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEPS - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t                state_q, state_d;
    logic [WAV_BITS-1:0]   wav_q, wav_d;
    logic [ENV_BITS-1:0]   env_q, env_d;
    logic [OUT_BITS-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [OUT_BITS-1:0]   out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overrun_q, overrun_d;

    logic                  start;
    logic                  last;
    logic [OUT_BITS-1:0]   wav_ext;
    logic [OUT_BITS-1:0]   partial;
    logic [OUT_BITS-1:0]   acc_next;
`ifdef SID_ENV_AMP_BOOTH_EN
    logic [ENV_BITS+2:0]   env_ext;
    logic [2:0]            trip;
    logic [OUT_BITS-1:0]   mag;
    logic [OUT_BITS-1:0]   pp;
`endif

    // Partial product for the current step and the running sum it produces
    always_comb begin
        start   = |(phase & (sid::phase_t'(1) << sid::PHI2));
        last    = (cnt_q == LAST);
        wav_ext = {{ENV_BITS{wav_q[WAV_BITS-1]}}, wav_q};
`ifdef SID_ENV_AMP_BOOTH_EN
        // Env zero-extended with an implicit 0 below bit 0; each digit
        // looks at the overlapping bit triplet (2i+1, 2i, 2i-1).
        env_ext = {2'b00, env_q, 1'b0};
        trip    = env_ext[{cnt_q, 1'b0} +: 3];
        case (trip)
            3'b001, 3'b010: mag = wav_ext;
            3'b011, 3'b100: mag = wav_ext << 1;
            3'b101, 3'b110: mag = wav_ext;
            default:        mag = '0;
        endcase
        pp      = mag << {cnt_q, 1'b0};
        partial = trip[2] ? ('0 - pp) : pp;
`else
        partial = env_q[cnt_q] ? (wav_ext << cnt_q) : '0;
`endif
        acc_next = acc_q + partial;
    end

    // Next-state: start, step, completion, and abort-on-restrike
    always_comb begin
        state_d     = state_q;
        wav_d       = wav_q;
        env_d       = env_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        case (state_q)
            IDLE: ;
            MUL: begin
                if (last) begin
                    out_d       = acc_next;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A strobe always (re)starts; it only counts as an overrun when it
        // kills an operation that has not reached its last step.
        if (start) begin
            if (state_q == MUL && !last) overrun_d = 1'b1;
            wav_d   = {~wav[WAV_BITS-1], wav[WAV_BITS-2:0]};
            env_d   = env;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = MUL;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= IDLE;
            wav_q       <= '0;
            env_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wav_q       <= wav_d;
            env_q       <= env_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sid_env_amp.sv
// Testbench for sid_env_amp: directed cases plus randomized strobes checked
// against a transaction-level model (product by plain arithmetic, fixed
// latency in edges).
`timescale 1ns/1ps

module tb_sid_env_amp;
`ifdef SID_ENV_AMP_BOOTH_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 8;
`endif

    logic        clk;
    logic        res_n;
    sid::phase_t phase;
    logic [11:0] wav;
    logic [7:0]  env;
    logic [19:0] out;
    logic        out_valid;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          m_busy;
    int          m_k;
    int          m_prod;
    logic [19:0] m_out;
    logic        m_valid;
    logic        m_ovr;

    sid_env_amp #(.WAV_BITS(12), .ENV_BITS(8)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .phase     (phase),
        .wav       (wav),
        .env       (env),
        .out       (out),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_k = 0; m_prod = 0;
        m_out = '0; m_valid = 1'b0; m_ovr = 1'b0;
    endtask

    // One clock edge of the model, using the inputs present at that edge
    task automatic model_edge();
        m_valid = 1'b0;
        if (m_busy) begin
            m_k++;
            if (m_k == LAT) begin
                m_out   = 20'(m_prod);
                m_valid = 1'b1;
                m_busy  = 0;
            end
        end
        if (phase[sid::PHI2]) begin
            if (m_busy) m_ovr = 1'b1;
            m_busy = 1;
            m_k    = 0;
            m_prod = (int'(wav) - 2048) * int'(env);
        end
    endtask

    task automatic check_model();
        check("out", 32'(out), 32'(m_out));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // Called at a negedge: drive inputs, take one edge, check at next negedge
    task automatic step(input bit strobe, input logic [11:0] w, input logic [7:0] e);
        phase = '0;
        phase[sid::PHI2] = strobe;
        phase[sid::PHI1] = 1'($urandom_range(0, 1));
        wav = w;
        env = e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'($urandom), 8'($urandom));
    endtask

    task automatic do_op(input string tag, input logic [11:0] w, input logic [7:0] e,
                         input logic [19:0] exp);
        step(1'b1, w, e);
        idle(LAT);
        check(tag, 32'(out), 32'(exp));
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 res_n = 1'b0;
        #1;
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        model_clear();
        @(negedge clk);
        res_n = 1'b1;
    endtask

    initial begin
        res_n = 1'b0;
        phase = '0;
        wav   = '0;
        env   = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check("reset_out", 32'(out), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        res_n = 1'b1;
        idle(2);

        do_op("max_pos", 12'hFFF, 8'hFF, 20'h7F701);
        idle(1);
        check("valid_one_clk", 32'(out_valid), 32'd0);
        do_op("max_neg", 12'h000, 8'hFF, 20'h80800);
        do_op("neg_small", 12'h001, 8'h01, 20'hFF801);
        do_op("zero_mid", 12'h800, 8'hAB, 20'h00000);
        do_op("zero_env", 12'h123, 8'h00, 20'h00000);

        // strobe at the last-bit edge: both results, no overrun
        step(1'b1, 12'h900, 8'h10);
        idle(LAT - 1);
        step(1'b1, 12'h7FF, 8'h03);
        check("back2back_a", 32'(out), 32'h01000);
        check("back2back_ovr", 32'(overrun), 32'd0);
        idle(LAT);
        check("back2back_b", 32'(out), 32'hFFFFD);

        // operand stability: change inputs at E2
        step(1'b1, 12'hA00, 8'h05);
        step(1'b0, 12'hA00, 8'h05);
        step(1'b0, 12'h000, 8'hFF);
        idle(LAT - 2);
        check("stable", 32'(out), 32'h00A00);

        // overrun: restart at E4
        step(1'b1, 12'h456, 8'h77);
        idle(3);
        step(1'b1, 12'hC00, 8'h02);
        idle(LAT);
        check("overrun_out", 32'(out), 32'h00800);
        check("overrun_flag", 32'(overrun), 32'd1);
        idle(3);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // reset at E3 of an operation
        step(1'b1, 12'hFFF, 8'hFF);
        idle(2);
        async_reset();
        idle(LAT + 2);
        do_op("after_reset", 12'h801, 8'h80, 20'h00080);

        // randomized strobes, occasional resets
        for (int i = 0; i < 1500; i++) begin
            if (($urandom % 200) == 0) async_reset();
            else step(($urandom % 5) == 0, 12'($urandom), 8'($urandom));
        end
        idle(LAT + 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
